// File: rtl/kp_frame_sequencer.sv
// Frame scheduler for the 3x3 kernel line-buffer stage: feeds FIFO lines to the kernel
// controller, replays the last line twice as bottom border, then waits for all output pixels.
module kp_frame_sequencer #(
    parameter int LINE_LENGTH = 640,
    parameter int LINE_COUNT  = 480,
    parameter int DATA_WIDTH  = 8,
    parameter int REQ_GUARD   = 2
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_start,
    input  logic [DATA_WIDTH-1:0]               i_fifo_rdata,
    input  logic                                i_fifo_empty,
    output logic                                o_fifo_rd,
    input  logic                                i_kc_req,
    output logic [DATA_WIDTH-1:0]               o_kc_data,
    output logic                                o_kc_valid,
    input  logic                                i_kc_valid,
    output logic                                o_kc_flush,
    output logic                                o_busy,
    output logic                                o_frame_done,
    output logic [$clog2(LINE_COUNT+2)-1:0]     o_line_idx
);

    localparam int PIX_W  = $clog2(LINE_LENGTH + 1);
    localparam int ADDR_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
    localparam int LINE_W = $clog2(LINE_COUNT + 3);
    localparam int OUT_W  = $clog2(LINE_LENGTH * LINE_COUNT + 1);
    localparam int GRD_W  = (REQ_GUARD > 1) ? $clog2(REQ_GUARD + 1) : 1;
    localparam int IDX_W  = $clog2(LINE_COUNT + 2);

    localparam logic [PIX_W-1:0]  PIX_LAST    = PIX_W'(LINE_LENGTH - 1);
    localparam logic [PIX_W-1:0]  PIX_END     = PIX_W'(LINE_LENGTH);
    localparam logic [LINE_W-1:0] LINE_REAL   = LINE_W'(LINE_COUNT);
    localparam logic [LINE_W-1:0] LINE_TOTAL  = LINE_W'(LINE_COUNT + 2);
    localparam logic [LINE_W-1:0] LINE_MAXIDX = LINE_W'(LINE_COUNT + 1);
    localparam logic [OUT_W-1:0]  OUT_TARGET  = OUT_W'(LINE_LENGTH * LINE_COUNT);
    localparam logic [GRD_W-1:0]  GRD_LAST    = GRD_W'(REQ_GUARD - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GUARD    = 3'd1;
    localparam logic [2:0] S_WAIT_REQ = 3'd2;
    localparam logic [2:0] S_FEED     = 3'd3;
    localparam logic [2:0] S_PAD      = 3'd4;
    localparam logic [2:0] S_DRAIN    = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic [2:0]            state;
    logic [GRD_W-1:0]      guard_cnt;
    logic [LINE_W-1:0]     line_idx;
    logic [LINE_W-1:0]     line_next;
    logic [PIX_W-1:0]      issued;
    logic [PIX_W-1:0]      pix_out;
    logic [OUT_W-1:0]      out_cnt;
    logic                  valid_q;
    logic                  src_pad_q;
    logic                  ram_rd;
    logic                  rd_ok;
    logic                  line_end;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] ram [LINE_LENGTH];

    always_comb begin
        rd_ok     = (issued < PIX_END);
        o_fifo_rd = (state == S_FEED) && !i_fifo_empty && rd_ok;
        ram_rd    = (state == S_PAD) && rd_ok;
        line_end  = valid_q && (pix_out == PIX_LAST);
        line_next = line_idx + LINE_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            guard_cnt <= '0;
            line_idx  <= '0;
            issued    <= '0;
            pix_out   <= '0;
            out_cnt   <= '0;
            valid_q   <= 1'b0;
            src_pad_q <= 1'b0;
        end else begin
            valid_q   <= o_fifo_rd || ram_rd;
            src_pad_q <= ram_rd;
            if (o_fifo_rd || ram_rd) issued <= issued + PIX_W'(1);
            if (valid_q) pix_out <= pix_out + PIX_W'(1);
            // Output pixels are counted from the very first line and held at the target.
            if ((state != S_IDLE) && i_kc_valid && (out_cnt != OUT_TARGET))
                out_cnt <= out_cnt + OUT_W'(1);

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state     <= S_GUARD;
                        guard_cnt <= '0;
                        line_idx  <= '0;
                        issued    <= '0;
                        pix_out   <= '0;
                        out_cnt   <= '0;
                    end
                end
                S_GUARD: begin
                    if (guard_cnt == GRD_LAST) begin
                        state     <= S_WAIT_REQ;
                        guard_cnt <= '0;
                    end else begin
                        guard_cnt <= guard_cnt + GRD_W'(1);
                    end
                end
                S_WAIT_REQ: begin
                    if (i_kc_req) state <= (line_idx < LINE_REAL) ? S_FEED : S_PAD;
                end
                S_FEED: begin
                    if (line_end) begin
                        line_idx <= line_next;
                        issued   <= '0;
                        pix_out  <= '0;
                        state    <= S_GUARD;
                    end
                end
                S_PAD: begin
                    if (line_end) begin
                        line_idx <= line_next;
                        issued   <= '0;
                        pix_out  <= '0;
                        state    <= (line_next < LINE_TOTAL) ? S_GUARD : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_cnt == OUT_TARGET) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Replay RAM captures every fed pixel so the padding lines repeat the last real line.
    always_ff @(posedge i_clk) begin
        if (valid_q && !src_pad_q) ram[pix_out[ADDR_W-1:0]] <= i_fifo_rdata;
        if (ram_rd) ram_q <= ram[issued[ADDR_W-1:0]];
    end

    always_comb begin
        o_kc_valid   = valid_q;
        o_kc_data    = valid_q ? (src_pad_q ? ram_q : i_fifo_rdata) : '0;
        o_busy       = (state != S_IDLE) && (state != S_DONE);
        o_frame_done = (state == S_DONE);
        o_kc_flush   = (state == S_DONE);
        o_line_idx   = (line_idx > LINE_MAXIDX) ? IDX_W'(LINE_MAXIDX) : IDX_W'(line_idx);
    end

endmodule

// File: tb/tb_kp_frame_sequencer.sv
// Directed bench for kp_frame_sequencer: table of frame scenarios over a FIFO and
// kernel-controller model, plus hand-written reset sequences.
module tb_kp_frame_sequencer;

    localparam int LL    = 8;
    localparam int LC    = 4;
    localparam int DW    = 8;
    localparam int RG    = 2;
    localparam int IDX_W = $clog2(LC + 2);
    localparam int NPIX  = LL * (LC + 2);

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_start;
    logic [DW-1:0]    i_fifo_rdata;
    logic             i_fifo_empty;
    logic             o_fifo_rd;
    logic             i_kc_req;
    logic [DW-1:0]    o_kc_data;
    logic             o_kc_valid;
    logic             i_kc_valid;
    logic             o_kc_flush;
    logic             o_busy;
    logic             o_frame_done;
    logic [IDX_W-1:0] o_line_idx;

    kp_frame_sequencer #(
        .LINE_LENGTH (LL),
        .LINE_COUNT  (LC),
        .DATA_WIDTH  (DW),
        .REQ_GUARD   (RG)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_fifo_rdata (i_fifo_rdata),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_rd    (o_fifo_rd),
        .i_kc_req     (i_kc_req),
        .o_kc_data    (o_kc_data),
        .o_kc_valid   (o_kc_valid),
        .i_kc_valid   (i_kc_valid),
        .o_kc_flush   (o_kc_flush),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_line_idx   (o_line_idx)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int empty_period;   // 0: never forced empty
        bit kc_all;         // controller answers every pixel instead of rows 2..5
        int base;           // first pixel value in the FIFO
        bit feed_start;     // extra i_start during line 0
        bit req_drop;       // drop i_kc_req after pixel 3 of line 1
        bit drain_start;    // extra i_start in DRAIN
        int exp_ikv;        // i_kc_valid seen when o_frame_done fires
        int exp_lag;        // cycles from last o_kc_valid to o_frame_done
    } vec_t;

    vec_t vecs[4];

    int n_pass = 0;
    int n_total = 0;
    int q[$];
    bit rd_last, kcv_next, req_low, kc_all;
    int empty_period, base, cyc;
    int out_idx, ikv_cnt, done_cnt, done_cyc, last_valid_cyc;
    int data_err, lat_err, empty_err;
    int flush_at_done, busy_at_done, line_at_done, ikv_at_done, out_at_done;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int exp_pix(input int k);
        return (k < LL * LC) ? base + k : base + (LC - 1) * LL + (k % LL);
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        if (rd_last && q.size() > 0) i_fifo_rdata = DW'(q.pop_front());
        cyc++;
        i_fifo_empty = (q.size() == 0) || (empty_period != 0 && (cyc % empty_period) == 0);
        i_kc_valid   = kcv_next;
        i_kc_req     = !req_low;
        @(negedge i_clk);
        if (o_fifo_rd && i_fifo_empty) empty_err++;
        if (rd_last && !o_kc_valid) lat_err++;
        if (o_kc_valid && out_idx < LL * LC && !rd_last) lat_err++;
        ikv_cnt += int'(i_kc_valid);
        kcv_next = 1'b0;
        if (o_kc_valid) begin
            if (int'(o_kc_data) != exp_pix(out_idx)) data_err++;
            kcv_next = kc_all || (out_idx >= 2 * LL);
            out_idx++;
            last_valid_cyc = cyc;
        end
        if (o_frame_done) begin
            done_cnt++;
            done_cyc      = cyc;
            flush_at_done = int'(o_kc_flush);
            busy_at_done  = int'(o_busy);
            line_at_done  = int'(o_line_idx);
            ikv_at_done   = ikv_cnt;
            out_at_done   = out_idx;
        end
        rd_last = o_fifo_rd && !i_fifo_empty;
    endtask

    task automatic setup_frame(input vec_t e);
        q.delete();
        for (int k = 0; k < LL * LC; k++) q.push_back(e.base + k);
        empty_period = e.empty_period;
        kc_all       = e.kc_all;
        base         = e.base;
        rd_last      = 1'b0;
        kcv_next     = 1'b0;
        req_low      = 1'b0;
        out_idx = 0; ikv_cnt = 0; done_cnt = 0; done_cyc = -100; last_valid_cyc = -100;
        data_err = 0; lat_err = 0; empty_err = 0;
        i_start = 1'b1;
        tick();
        chk("busy_after_start", int'(o_busy), 1);
        chk("line_idx_at_start", int'(o_line_idx), 0);
    endtask

    task automatic run_frame(input vec_t e);
        bit fs_done, dr_done, dropped;
        int hold;
        fs_done = 0; dr_done = 0; dropped = 0; hold = 0;
        setup_frame(e);
        for (int n = 0; n < 3000 && done_cnt == 0; n++) begin
            if (e.feed_start && !fs_done && out_idx == 3) begin
                i_start = 1'b1;
                fs_done = 1;
            end
            if (e.req_drop && !dropped && out_idx == LL + 4) begin
                req_low = 1'b1;
                dropped = 1;
                hold    = 30;
            end
            if (e.drain_start && !dr_done && out_idx == NPIX && cyc == last_valid_cyc + 1) begin
                i_start = 1'b1;
                dr_done = 1;
            end
            tick();
            if (hold > 0) begin
                hold--;
                if (hold == 0) begin
                    chk("req_low_holds_after_line1", out_idx, 2 * LL);
                    req_low = 1'b0;
                end
            end
        end
        chk("frame_done_seen", int'(done_cnt > 0), 1);
        chk("valids_at_done", out_at_done, NPIX);
        chk("kc_valid_count_at_done", ikv_at_done, e.exp_ikv);
        chk("done_lag", done_cyc - last_valid_cyc, e.exp_lag);
        chk("flush_with_done", flush_at_done, 1);
        chk("busy_low_at_done", busy_at_done, 0);
        chk("line_idx_at_done", line_at_done, LC + 1);
        chk("data_errors", data_err, 0);
        chk("latency_errors", lat_err, 0);
        chk("read_while_empty", empty_err, 0);
        for (int n = 0; n < 6; n++) tick();
        chk("single_done_pulse", done_cnt, 1);
        chk("no_extra_valids", out_idx, NPIX);
        chk("idle_after_done", int'(o_busy), 0);
    endtask

    initial begin
        vecs[0] = '{0, 1'b0, 0,   1'b0, 1'b0, 1'b0, 32, 3};
        vecs[1] = '{3, 1'b0, 50,  1'b0, 1'b0, 1'b0, 32, 3};
        vecs[2] = '{0, 1'b1, 100, 1'b0, 1'b0, 1'b0, 48, 2};
        vecs[3] = '{0, 1'b0, 7,   1'b1, 1'b1, 1'b1, 32, 3};

        i_rst = 1'b1; i_start = 1'b0; i_fifo_rdata = '0; i_fifo_empty = 1'b1;
        i_kc_req = 1'b1; i_kc_valid = 1'b0;
        rd_last = 0; kcv_next = 0; req_low = 0; kc_all = 0; empty_period = 0; base = 0; cyc = 0;
        out_idx = 0; ikv_cnt = 0; done_cnt = 0; data_err = 0; lat_err = 0; empty_err = 0;
        for (int n = 0; n < 3; n++) tick();
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_fifo_rd", int'(o_fifo_rd), 0);
        chk("rst_kc_valid", int'(o_kc_valid), 0);
        chk("rst_kc_data", int'(o_kc_data), 0);
        chk("rst_line_idx", int'(o_line_idx), 0);
        chk("rst_frame_done", int'(o_frame_done), 0);
        chk("rst_kc_flush", int'(o_kc_flush), 0);
        i_rst = 1'b0;
        tick();

        for (int v = 0; v < 4; v++) run_frame(vecs[v]);

        // Reset in the middle of line 2, pixel 5.
        setup_frame(vecs[0]);
        for (int n = 0; n < 500 && out_idx < 2 * LL + 6; n++) tick();
        chk("reached_line2_px5", out_idx, 2 * LL + 6);
        i_rst = 1'b1;
        tick();
        chk("midrst_fifo_rd", int'(o_fifo_rd), 0);
        chk("midrst_kc_valid", int'(o_kc_valid), 0);
        chk("midrst_kc_data", int'(o_kc_data), 0);
        chk("midrst_busy", int'(o_busy), 0);
        chk("midrst_line_idx", int'(o_line_idx), 0);
        chk("midrst_done", int'(o_frame_done), 0);
        chk("midrst_flush", int'(o_kc_flush), 0);
        i_rst = 1'b0;
        for (int n = 0; n < 4; n++) tick();
        chk("idle_no_read_after_rst", int'(o_fifo_rd), 0);
        chk("idle_not_busy_after_rst", int'(o_busy), 0);
        run_frame(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
